// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions: opcodes, instruction field positions and the fetch FSM states.
package lc2k_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_NOR  = 3'b001;
  localparam logic [2:0] OP_LW   = 3'b010;
  localparam logic [2:0] OP_SW   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_JALR = 3'b101;
  localparam logic [2:0] OP_HALT = 3'b110;
  localparam logic [2:0] OP_NOOP = 3'b111;

  localparam int unsigned OP_HI     = 24;
  localparam int unsigned OP_LO     = 22;
  localparam int unsigned REGA_HI   = 21;
  localparam int unsigned REGA_LO   = 19;
  localparam int unsigned REGB_HI   = 18;
  localparam int unsigned REGB_LO   = 16;
  localparam int unsigned DEST_HI   = 2;
  localparam int unsigned DEST_LO   = 0;
  localparam int unsigned OFFSET_HI = 15;
  localparam int unsigned OFFSET_LO = 0;

  localparam logic [31:0] NOOP_INSTR = 32'h01C0_0000;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_WAIT   = 2'd1,
    ST_OUT    = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

  function automatic logic [2:0] opcode_of(input logic [31:0] instr);
    return instr[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/lc2k_fetch.sv
// LC2K instruction fetch: owns the PC, issues one word read at a time and feeds IF/ID.
module lc2k_fetch
  import lc2k_pkg::*;
#(
  parameter int unsigned           PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_rvalid,
  input  logic [31:0]         imem_rdata,
  output logic                ifid_valid,
  input  logic                ifid_ready,
  output logic [31:0]         ifid_instr,
  output logic [PC_WIDTH-1:0] ifid_pc,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic                halted
);

  fetch_state_e        state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [PC_WIDTH-1:0] req_pc_q, req_pc_d;
  logic [PC_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [31:0]         instr_q, instr_d;
  logic                drop_q, drop_d;
  logic                valid_q, valid_d;
  logic                halted_q, halted_d;
  logic                held_halt;
  logic                issue;

  assign imem_addr  = redirect_valid ? redirect_pc : pc_q;
  assign imem_req   = issue;
  assign ifid_valid = valid_q;
  assign ifid_instr = instr_q;
  assign ifid_pc    = ifid_pc_q;
  assign halted     = halted_q;

  always_comb begin
    held_halt = (opcode_of(instr_q) == OP_HALT);
    issue     = 1'b0;
    unique case (state_q)
      ST_FETCH: issue = 1'b1;
      // A redirect squashes the held word, so it issues even under backpressure or HALT.
      ST_OUT:   issue = redirect_valid || (ifid_ready && !held_halt);
      default:  issue = 1'b0;
    endcase
    if (reset) issue = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    ifid_pc_d = ifid_pc_q;
    instr_d   = instr_q;
    drop_d    = drop_q;
    valid_d   = valid_q;
    halted_d  = halted_q;

    if (issue) begin
      req_pc_d = imem_addr;
      pc_d     = imem_addr + PC_WIDTH'(1);
      state_d  = ST_WAIT;
    end

    unique case (state_q)
      ST_WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid) begin
            pc_d    = redirect_pc;
            drop_d  = 1'b0;
            state_d = ST_FETCH;
          end else if (drop_q) begin
            drop_d  = 1'b0;
            state_d = ST_FETCH;
          end else begin
            instr_d   = imem_rdata;
            ifid_pc_d = req_pc_q;
            valid_d   = 1'b1;
            state_d   = ST_OUT;
          end
        end else if (redirect_valid) begin
          drop_d = 1'b1;
          pc_d   = redirect_pc;
        end
      end
      ST_OUT: begin
        if (redirect_valid || ifid_ready) begin
          valid_d = 1'b0;
          if (!redirect_valid && held_halt) begin
            halted_d = 1'b1;
            state_d  = ST_HALTED;
          end
        end
      end
      ST_HALTED: begin
        if (redirect_valid) begin
          halted_d = 1'b0;
          pc_d     = redirect_pc;
          state_d  = ST_FETCH;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      req_pc_q  <= '0;
      ifid_pc_q <= '0;
      instr_q   <= NOOP_INSTR;
      drop_q    <= 1'b0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      ifid_pc_q <= ifid_pc_d;
      instr_q   <= instr_d;
      drop_q    <= drop_d;
      valid_q   <= valid_d;
      halted_q  <= halted_d;
    end
  end

  rvalid_only_in_wait: assert property (@(posedge clock) disable iff (reset)
    imem_rvalid |-> (state_q == ST_WAIT));

endmodule

// File: tb/tb_lc2k_fetch.sv
// Self-checking bench for lc2k_fetch: directed scenarios plus a randomized stream against a PC-order model.
module tb_lc2k_fetch;
  import lc2k_pkg::*;

  localparam int unsigned PCW = 16;
  localparam logic [31:0] HALT_WORD = 32'h0180_0000;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            imem_req;
  logic [PCW-1:0]  imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;
  logic            ifid_valid;
  logic            ifid_ready;
  logic [31:0]     ifid_instr;
  logic [PCW-1:0]  ifid_pc;
  logic            redirect_valid;
  logic [PCW-1:0]  redirect_pc;
  logic            halted;

  logic            w_reset = 1'b1;
  logic            w_req, w_rvalid, w_valid, w_halted;
  logic            w_ready = 1'b1;
  logic            w_redir = 1'b0;
  logic [3:0]      w_redir_pc = 4'd0;
  logic [3:0]      w_addr, w_pc;
  logic [31:0]     w_rdata, w_instr;

  int              vectors = 0;
  int              miscompares = 0;

  logic [31:0]     mem [64];
  int unsigned     mem_lat = 1;
  int unsigned     mem_cnt;
  logic [5:0]      mem_addr;

  lc2k_fetch #(.PC_WIDTH(PCW), .RESET_PC(16'd0)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .ifid_valid(ifid_valid), .ifid_ready(ifid_ready),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted)
  );

  lc2k_fetch #(.PC_WIDTH(4), .RESET_PC(4'd15)) u_wrap (
    .clock(clock), .reset(w_reset),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rvalid(w_rvalid), .imem_rdata(w_rdata),
    .ifid_valid(w_valid), .ifid_ready(w_ready),
    .ifid_instr(w_instr), .ifid_pc(w_pc),
    .redirect_valid(w_redir), .redirect_pc(w_redir_pc),
    .halted(w_halted)
  );

  always #5 clock = ~clock;

  // Instruction memory with a per-request latency of mem_lat cycles.
  always @(posedge clock) begin
    imem_rvalid <= 1'b0;
    if (reset) begin
      mem_cnt <= 0;
    end else if (imem_req) begin
      if (mem_lat <= 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem[imem_addr[5:0]];
      end else begin
        mem_cnt  <= mem_lat - 1;
        mem_addr <= imem_addr[5:0];
      end
    end else if (mem_cnt != 0) begin
      mem_cnt <= mem_cnt - 1;
      if (mem_cnt == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem[mem_addr];
      end
    end
  end

  always @(posedge clock) begin
    w_rvalid <= !w_reset && w_req;
    w_rdata  <= {7'd0, OP_ADD, 18'd0, w_addr};
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    ifid_ready = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [2:0]  op;
    w  = $urandom;
    op = 3'($urandom_range(0, 5));
    if ($urandom_range(0, 6) == 0) op = OP_NOOP;
    w[24:22] = op;
    return w;
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 64; i++) mem[i] = rand_word();
  endtask

  task automatic test_reset();
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; ifid_ready = 1'b0; mem_lat = 1;
    cyc(); #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req_low: got %b expected 0", imem_req); end
    cyc(); reset = 1'b0; #1;
    vectors++; if (ifid_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", ifid_valid); end
    vectors++; if (ifid_instr !== NOOP_INSTR) begin miscompares++; $display("FAIL reset_instr: got %h expected %h", ifid_instr, NOOP_INSTR); end
    vectors++; if (ifid_pc !== 16'd0) begin miscompares++; $display("FAIL reset_ifid_pc: got %h expected 0", ifid_pc); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b expected 0", halted); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'd0) begin miscompares++; $display("FAIL reset_first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
  endtask

  // Stream with 1-cycle memory, then 5 cycles of backpressure while pc 3 is held.
  task automatic test_stream_backpressure();
    for (int i = 0; i < 64; i++) mem[i] = {7'd0, OP_ADD, 6'd0, 16'(i)};
    mem_lat = 1;
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      ifid_ready = (c >= 8 && c <= 12) ? 1'b0 : 1'b1;
      #1;
      if (c <= 7) begin
        logic exp_req, exp_valid;
        exp_req   = (c % 2 == 0);
        exp_valid = (c >= 2) && (c % 2 == 0);
        vectors++; if (imem_req !== exp_req) begin miscompares++; $display("FAIL stream_req c=%0d: got %b expected %b", c, imem_req, exp_req); end
        if (exp_req) begin
          vectors++; if (imem_addr !== 16'(c / 2)) begin miscompares++; $display("FAIL stream_addr c=%0d: got %h expected %h", c, imem_addr, c / 2); end
        end
        vectors++; if (ifid_valid !== exp_valid) begin miscompares++; $display("FAIL stream_valid c=%0d: got %b expected %b", c, ifid_valid, exp_valid); end
        if (exp_valid) begin
          vectors++; if (ifid_pc !== 16'(c / 2 - 1) || ifid_instr !== mem[c / 2 - 1]) begin
            miscompares++; $display("FAIL stream_data c=%0d: got pc=%h instr=%h expected pc=%h instr=%h", c, ifid_pc, ifid_instr, c / 2 - 1, mem[c / 2 - 1]);
          end
        end
      end else if (c <= 12) begin
        vectors++; if (ifid_valid !== 1'b1 || ifid_pc !== 16'd3 || ifid_instr !== mem[3] || imem_req !== 1'b0) begin
          miscompares++; $display("FAIL backpressure_hold c=%0d: got v=%b pc=%h instr=%h req=%b expected v=1 pc=3 instr=%h req=0", c, ifid_valid, ifid_pc, ifid_instr, imem_req, mem[3]);
        end
      end else begin
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'd4) begin miscompares++; $display("FAIL backpressure_release: got req=%b addr=%h expected req=1 addr=4", imem_req, imem_addr); end
      end
      cyc();
    end
  endtask

  task automatic test_redirect_wait();
    logic           seen_req, got;
    logic [PCW-1:0] first_addr;
    int             n;
    fill_random();
    mem_lat = 3;
    do_reset();
    ifid_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'd5; #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'd5) begin miscompares++; $display("FAIL rwait_req5: got req=%b addr=%h expected req=1 addr=5", imem_req, imem_addr); end
    cyc();
    redirect_pc = 16'd20; #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rwait_no_req: got %b expected 0", imem_req); end
    cyc();
    redirect_valid = 1'b0;
    seen_req = 1'b0; got = 1'b0; first_addr = '0; n = 0;
    while (!got && n < 30) begin
      #1;
      if (imem_req && !seen_req) begin seen_req = 1'b1; first_addr = imem_addr; end
      if (ifid_valid) got = 1'b1;
      else begin cyc(); n++; end
    end
    vectors++; if (!seen_req || first_addr !== 16'd20) begin miscompares++; $display("FAIL rwait_next_req: got seen=%b addr=%h expected addr=20", seen_req, first_addr); end
    vectors++; if (!got || ifid_pc !== 16'd20 || ifid_instr !== mem[20]) begin
      miscompares++; $display("FAIL rwait_deliver: got valid=%b pc=%h instr=%h expected pc=20 instr=%h", got, ifid_pc, ifid_instr, mem[20]);
    end
  endtask

  task automatic test_redirect_out();
    int n;
    fill_random();
    mem_lat = 1;
    do_reset();
    ifid_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 16'd7; #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'd7) begin miscompares++; $display("FAIL rout_req7: got req=%b addr=%h expected req=1 addr=7", imem_req, imem_addr); end
    cyc();
    redirect_valid = 1'b0;
    n = 0;
    while (n < 20) begin #1; if (ifid_valid) break; cyc(); n++; end
    vectors++; if (ifid_valid !== 1'b1 || ifid_pc !== 16'd7) begin miscompares++; $display("FAIL rout_hold7: got valid=%b pc=%h expected valid=1 pc=7", ifid_valid, ifid_pc); end
    ifid_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 16'd2; #1;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 16'd2) begin miscompares++; $display("FAIL rout_req2: got req=%b addr=%h expected req=1 addr=2", imem_req, imem_addr); end
    cyc();
    redirect_valid = 1'b0; #1;
    vectors++; if (ifid_valid !== 1'b0) begin miscompares++; $display("FAIL rout_squash: got valid=%b expected 0", ifid_valid); end
    n = 0;
    while (n < 20) begin if (ifid_valid) break; cyc(); #1; n++; end
    vectors++; if (ifid_valid !== 1'b1 || ifid_pc !== 16'd2 || ifid_instr !== mem[2]) begin
      miscompares++; $display("FAIL rout_deliver2: got valid=%b pc=%h instr=%h expected pc=2 instr=%h", ifid_valid, ifid_pc, ifid_instr, mem[2]);
    end
  endtask

  task automatic test_halt();
    int n, reqs, not_halted;
    fill_random();
    mem[4] = HALT_WORD;
    mem_lat = 1;
    do_reset();
    ifid_ready = 1'b1;
    n = 0;
    while (n < 30) begin #1; if (ifid_valid && ifid_pc == 16'd4) break; cyc(); n++; end
    vectors++; if (ifid_valid !== 1'b1 || ifid_pc !== 16'd4 || ifid_instr !== HALT_WORD || imem_req !== 1'b0) begin
      miscompares++; $display("FAIL halt_deliver: got v=%b pc=%h instr=%h req=%b expected v=1 pc=4 instr=%h req=0", ifid_valid, ifid_pc, ifid_instr, imem_req, HALT_WORD);
    end
    cyc(); #1;
    vectors++; if (halted !== 1'b1 || ifid_valid !== 1'b0) begin miscompares++; $display("FAIL halt_state: got halted=%b valid=%b expected halted=1 valid=0", halted, ifid_valid); end
    reqs = 0; not_halted = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) reqs++;
      if (!halted) not_halted++;
      cyc(); #1;
    end
    vectors++; if (reqs != 0 || not_halted != 0) begin miscompares++; $display("FAIL halt_quiet: got reqs=%0d unhalted_cycles=%0d expected 0 and 0", reqs, not_halted); end
    redirect_valid = 1'b1; redirect_pc = 16'd9; #1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL halt_redirect_cycle: got req=%b expected 0", imem_req); end
    cyc();
    redirect_valid = 1'b0; #1;
    vectors++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'd9) begin
      miscompares++; $display("FAIL halt_resume: got halted=%b req=%b addr=%h expected halted=0 req=1 addr=9", halted, imem_req, imem_addr);
    end
  endtask

  // Model: delivered words follow program order from the last redirect target.
  task automatic test_random();
    logic [PCW-1:0] exp_pc, prev_pc;
    logic [31:0]    prev_instr;
    logic           prev_hold;
    int             deliveries;
    fill_random();
    mem_lat = 1;
    do_reset();
    exp_pc = '0; prev_hold = 1'b0; prev_pc = '0; prev_instr = '0; deliveries = 0;
    for (int i = 0; i < 400; i++) begin
      ifid_ready     = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 16'($urandom_range(0, 63));
      mem_lat        = $urandom_range(1, 3);
      #1;
      if (prev_hold) begin
        vectors++; if (ifid_valid !== 1'b1 || ifid_pc !== prev_pc || ifid_instr !== prev_instr) begin
          miscompares++; $display("FAIL random_stable i=%0d: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", i, ifid_valid, ifid_pc, ifid_instr, prev_pc, prev_instr);
        end
      end
      if (ifid_valid && ifid_ready && !redirect_valid) begin
        vectors++; if (ifid_pc !== exp_pc || ifid_instr !== mem[exp_pc[5:0]]) begin
          miscompares++; $display("FAIL random_deliver i=%0d: got pc=%h instr=%h expected pc=%h instr=%h", i, ifid_pc, ifid_instr, exp_pc, mem[exp_pc[5:0]]);
        end
        exp_pc++;
        deliveries++;
      end
      if (redirect_valid) exp_pc = redirect_pc;
      prev_hold  = ifid_valid && !ifid_ready && !redirect_valid;
      prev_pc    = ifid_pc;
      prev_instr = ifid_instr;
      cyc();
    end
    redirect_valid = 1'b0;
    vectors++; if (deliveries < 20) begin miscompares++; $display("FAIL random_progress: got %0d deliveries expected at least 20", deliveries); end
  endtask

  task automatic test_wrap();
    logic [3:0] pcs [3];
    logic [31:0] ins [3];
    int got, n;
    w_reset = 1'b1;
    cyc(); cyc();
    w_reset = 1'b0; #1;
    vectors++; if (w_req !== 1'b1 || w_addr !== 4'd15) begin miscompares++; $display("FAIL wrap_first_req: got req=%b addr=%h expected req=1 addr=f", w_req, w_addr); end
    got = 0; n = 0;
    while (got < 3 && n < 20) begin
      if (w_valid) begin pcs[got] = w_pc; ins[got] = w_instr; got++; end
      cyc(); #1; n++;
    end
    vectors++; if (got != 3) begin miscompares++; $display("FAIL wrap_count: got %0d deliveries expected 3", got); end
    for (int k = 0; k < got; k++) begin
      logic [3:0] ep;
      ep = 4'(15 + k);
      vectors++; if (pcs[k] !== ep || ins[k] !== {7'd0, OP_ADD, 18'd0, ep}) begin
        miscompares++; $display("FAIL wrap_seq k=%0d: got pc=%h instr=%h expected pc=%h", k, pcs[k], ins[k], ep);
      end
    end
    vectors++; if (w_halted !== 1'b0) begin miscompares++; $display("FAIL wrap_halted: got %b expected 0", w_halted); end
  endtask

  initial begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    ifid_ready     = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = NOOP_INSTR;
    test_reset();
    test_stream_backpressure();
    test_redirect_wait();
    test_redirect_out();
    test_halt();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lc2k_fetch.md
Name: lc2k_fetch

Overview:
Instruction-fetch stage of the LC2K pipeline. It sits directly upstream of decode and owns the PC. It issues word reads to instruction memory and captures each returned word into the IF/ID register with a valid/ready handshake. It also handles branch/JALR redirects from EX and stops fetching after a HALT.

Parameters:
PC_WIDTH, 16, word-address width; the PC wraps modulo 2^PC_WIDTH.
RESET_PC, 0, PC loaded on reset.

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
imem_req  out  1  read request, single-cycle pulse per fetch
imem_addr  out  PC_WIDTH  word address of the request
imem_rvalid  in  1  read data valid; arrives at least 1 cycle after imem_req
imem_rdata  in  32  instruction word
ifid_valid  out  1  IF/ID register holds a live instruction
ifid_ready  in  1  decode accepts ifid_* this cycle
ifid_instr  out  32  fetched instruction
ifid_pc  out  PC_WIDTH  address of ifid_instr
redirect_valid  in  1  EX redirect (taken BEQ or JALR)
redirect_pc  in  PC_WIDTH  redirect target
halted  out  1  HALT delivered to decode; fetch stopped

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: pc=RESET_PC, state=FETCH, drop=0, ifid_valid=0, ifid_instr=NOOP_INSTR (32'h01C00000), ifid_pc=0, halted=0. imem_req is 0 during reset.
- States: FETCH, WAIT, OUT, HALTED. Exactly one request is outstanding at a time.
- imem_addr = redirect_valid ? redirect_pc : pc. This path is combinational.
- Issue condition:
  - state==FETCH, or
  - state==OUT and ifid_ready=1 and ifid_instr[24:22]!=HALT.
- When issue holds, imem_req=1. On the same edge: req_pc<=imem_addr, pc<=imem_addr+1 (wraps to 0), state<=WAIT.
- WAIT:
  - On imem_rvalid with drop=0 and redirect_valid=0: ifid_instr<=rdata, ifid_pc<=req_pc, ifid_valid<=1, state<=OUT.
  - On imem_rvalid with drop=1: discard the data, drop<=0, state<=FETCH.
- OUT:
  - ifid_* is held stable while ifid_ready=0.
  - On ifid_ready=1 with a non-HALT instruction: the next request issues in the same cycle, and ifid_valid<=0 unless a new capture occurs.
  - On ifid_ready=1 with HALT: ifid_valid<=0, halted<=1, state<=HALTED, no request issued.
- Redirect handling, by state:
  - FETCH: the request goes to redirect_pc.
  - OUT: ifid_valid<=0, the held instruction is squashed even if ifid_ready=1, and a request issues at redirect_pc in the same cycle.
  - WAIT without rvalid: drop<=1, pc<=redirect_pc.
  - WAIT with rvalid in the same cycle: the data is discarded, pc<=redirect_pc, state<=FETCH, and drop is left at 0.
  - HALTED: halted<=0, pc<=redirect_pc, state<=FETCH.
- Throughput is 1 instruction per 2 cycles with 1-cycle memory and ifid_ready held high.
- Fetch latency: ifid_valid rises 1 cycle after the imem_rvalid cycle.
- imem_rvalid outside WAIT is a protocol error: it is ignored and flagged by an assertion.
- Reset asserted mid-operation overrides everything. Any in-flight response is ignored because the state is forced to FETCH with drop cleared. Memory must not return stale data after reset; this is a bench constraint.

Decomposition:
- Shared package lc2k_pkg holds:
  - opcode constants ADD..NOOP (3'b000..3'b111);
  - field positions: OP 24:22, REGA 21:19, REGB 18:16, DEST 2:0, OFFSET 15:0;
  - NOOP_INSTR;
  - a state enum for fetch.
- No sub-module is needed. The FSM, PC register and IF/ID register all live in one module.

Test Plan:
- Reset then stream: RESET_PC=0, 1-cycle memory, rdata=addr-encoded ADDs, ifid_ready=1 -> ifid_pc sequence 0,1,2,3, one valid every 2 cycles, first ifid_valid at cycle 2 after reset release.
- Backpressure: ifid_ready=0 for 5 cycles while ifid_pc=3 -> ifid_instr/ifid_pc stable, imem_req=0; ready=1 -> request to address 4 in the same cycle.
- Redirect in WAIT with 3-cycle memory: redirect_pc=20 one cycle after the request to 5 -> response for 5 dropped, next request addr 20, next ifid_pc=20.
- Redirect in OUT: ifid_pc=7 valid, redirect_pc=2 with ifid_ready=1 -> pc 7 squashed, imem_addr=2 that cycle, next ifid_pc=2.
- HALT: word at addr 4 = 32'h01800000 -> delivered with ifid_pc=4, then halted=1 and no further imem_req for 10 cycles; redirect_pc=9 -> halted=0, request to 9.
- Wrap: PC_WIDTH=4, RESET_PC=15 -> ifid_pc 15 then 0.
